// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin time-share controller for one registered signed
// multiplier. Grants at most one requester per clock. Registers the granted
// operands toward the multiplier. Carries a {valid, id} tag alongside the
// multiplier latency, so each product returns to the requester that issued it.
module mul_arbiter #(
  parameter int N   = 4,
  parameter int W   = 18,
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_in,
  input  logic [N*W-1:0]   b_in,
  output logic [N-1:0]     gnt,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_p,
  output logic [N-1:0]     res_valid,
  output logic [2*W-1:0]   res_p,
  output logic             busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]  ptr_r;
  logic [PW-1:0]  gnt_id_s;
  logic           found_s;
  logic [N-1:0]   gnt_s;

  logic           iss_v_r;
  logic [PW-1:0]  iss_id_r;
  logic [LAT-1:0] tag_v_r;
  logic [PW-1:0]  tag_id_r [LAT];

  logic [W-1:0]   mul_a_r;
  logic [W-1:0]   mul_b_r;
  logic [N-1:0]   res_onehot_s;
  logic [N-1:0]   res_valid_r;
  logic [2*W-1:0] res_p_r;

  // Round-robin search: first requester at or after ptr, wrapping mod N.
  always_comb begin
    int sum;
    logic [PW-1:0] idx;
    sum      = 0;
    idx      = '0;
    found_s  = 1'b0;
    gnt_id_s = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr_r) + k;
      if (sum >= N) begin
        sum = sum - N;
      end else begin
        sum = sum;
      end
      idx = PW'(sum);
      if (!found_s && req[idx]) begin
        found_s  = 1'b1;
        gnt_id_s = idx;
      end else begin
        gnt_id_s = gnt_id_s;
      end
    end
    gnt_s = '0;
    // Grant is held off while reset is asserted, so nothing can be captured.
    if (found_s && rst_n) begin
      gnt_s[gnt_id_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // Pointer advances past the winner; it stays put on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= (gnt_id_s == PW'(N - 1)) ? '0 : gnt_id_s + 1'b1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Issue register: capture the winner's operands and tag; hold operands when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_r  <= '0;
      mul_b_r  <= '0;
      iss_v_r  <= 1'b0;
      iss_id_r <= '0;
    end else if (found_s) begin
      mul_a_r  <= a_in[gnt_id_s*W +: W];
      mul_b_r  <= b_in[gnt_id_s*W +: W];
      iss_v_r  <= 1'b1;
      iss_id_r <= gnt_id_s;
    end else begin
      mul_a_r  <= mul_a_r;
      mul_b_r  <= mul_b_r;
      iss_v_r  <= 1'b0;
      iss_id_r <= iss_id_r;
    end
  end

  // Tag pipeline tracks the multiplier latency so the last stage lines up with mul_p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_r <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_id_r[i] <= '0;
      end
    end else begin
      tag_v_r[0]  <= iss_v_r;
      tag_id_r[0] <= iss_id_r;
      for (int i = 1; i < LAT; i++) begin
        tag_v_r[i]  <= tag_v_r[i-1];
        tag_id_r[i] <= tag_id_r[i-1];
      end
    end
  end

  // Decode the aligned tag into a one-hot return strobe.
  always_comb begin
    res_onehot_s = '0;
    if (tag_v_r[LAT-1]) begin
      res_onehot_s = {{(N-1){1'b0}}, 1'b1} << tag_id_r[LAT-1];
    end else begin
      res_onehot_s = '0;
    end
  end

  // Output register: product passes through every clock; strobe marks real results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= '0;
      res_p_r     <= '0;
    end else begin
      res_valid_r <= res_onehot_s;
      res_p_r     <= mul_p;
    end
  end

  assign gnt       = gnt_s;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign res_valid = res_valid_r;
  assign res_p     = res_p_r;
  assign busy      = iss_v_r | (|tag_v_r);

endmodule
